// File: rtl/decode_2_4_stream.sv
// Registered 2-to-4 decoder behind a 2-entry skid buffer. It keeps a saturating count of V=1 codes.
// Define DECODE_LAST_HOLD_EN to keep the last popped word on the outputs while idle.
module decode_2_4_stream #(
  parameter int IN_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_v,
  input  logic [IN_W-1:0]        in_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(1<<IN_W)-1:0]   out_onehot,
  output logic                   out_v,
  output logic [CNT_W-1:0]       dec_cnt
);
  localparam int OUT_W = 1 << IN_W;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   head_oh_q, head_oh_d, tail_oh_q, tail_oh_d, in_oh;
  logic               head_v_q, head_v_d, tail_v_q, tail_v_d;
  logic               in_ready_q, in_ready_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept, pop;

  // Words are decoded on entry; with in_v=0 the select ignores in_y entirely.
  always_comb begin
    in_oh = in_v ? (OUT_W'(1) << in_y) : '0;
  end

  always_comb begin
    state_d   = state_q;
    head_oh_d = head_oh_q;
    head_v_d  = head_v_q;
    tail_oh_d = tail_oh_q;
    tail_v_d  = tail_v_q;
    cnt_d     = cnt_q;
    accept    = in_valid & in_ready_q;
    pop       = (state_q != EMPTY) & out_ready;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          head_oh_d = in_oh;
          head_v_d  = in_v;
        end
      end
      ONE: begin
        if (accept && pop) begin
          head_oh_d = in_oh;
          head_v_d  = in_v;
        end else if (accept) begin
          state_d   = TWO;
          tail_oh_d = in_oh;
          tail_v_d  = in_v;
        end else if (pop) begin
          state_d   = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d   = ONE;
          head_oh_d = tail_oh_q;
          head_v_d  = tail_v_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    in_ready_d = (state_d != TWO);

    if (accept && in_v && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_oh_q  <= '0;
      head_v_q   <= 1'b0;
      tail_oh_q  <= '0;
      tail_v_q   <= 1'b0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      head_oh_q  <= head_oh_d;
      head_v_q   <= head_v_d;
      tail_oh_q  <= tail_oh_d;
      tail_v_q   <= tail_v_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign dec_cnt   = cnt_q;

  // The head slot is not cleared on the final pop, so it still holds the last popped word.
`ifdef DECODE_LAST_HOLD_EN
  assign out_onehot = head_oh_q;
  assign out_v      = head_v_q;
`else
  assign out_onehot = out_valid ? head_oh_q : '0;
  assign out_v      = out_valid & head_v_q;
`endif

endmodule

// File: tb/tb_decode_2_4_stream.sv
// Bench for decode_2_4_stream: directed steps plus random traffic against a FIFO-queue model.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_decode_2_4_stream;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_v, out_ready;
  logic [1:0] in_y;
  logic       in_ready, out_valid, out_v;
  logic [3:0] out_onehot;
  logic [7:0] dec_cnt;
  logic       s_in_ready, s_out_valid, s_out_v;
  logic [3:0] s_out_onehot;
  logic [1:0] s_dec_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {int oh; bit v;} word_t;
  word_t mq[$];
  int    m_cnt, m_cnt2, last_oh;
  bit    last_v;

  always #5 clk = ~clk;

  decode_2_4_stream #(.IN_W(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_v(in_v), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .out_v(out_v), .dec_cnt(dec_cnt)
  );

  decode_2_4_stream #(.IN_W(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_v(in_v), .in_y(in_y), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_onehot(s_out_onehot), .out_v(s_out_v), .dec_cnt(s_dec_cnt)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    int exp_oh;
    bit exp_v;
    if (mq.size() > 0) begin
      exp_oh = mq[0].oh;
      exp_v  = mq[0].v;
    end else begin
`ifdef DECODE_LAST_HOLD_EN
      exp_oh = last_oh;
      exp_v  = last_v;
`else
      exp_oh = 0;
      exp_v  = 1'b0;
`endif
    end
    chk({tag, ".out_valid"},  32'(out_valid),  32'(mq.size() > 0));
    chk({tag, ".in_ready"},   32'(in_ready),   32'(mq.size() < 2));
    chk({tag, ".out_onehot"}, 32'(out_onehot), 32'(exp_oh));
    chk({tag, ".out_v"},      32'(out_v),      32'(exp_v));
    chk({tag, ".dec_cnt"},    32'(dec_cnt),    32'(m_cnt));
    chk({tag, ".sat_cnt"},    32'(s_dec_cnt),  32'(m_cnt2));
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt   = 0;
    m_cnt2  = 0;
    last_oh = 0;
    last_v  = 1'b0;
  endtask

  // Called just after a rising edge: drive, check before the next edge, then advance the model.
  task automatic cycle(string tag, bit iv, bit v, logic [1:0] y, bit ordy);
    bit    acc, pp;
    word_t w;
    in_valid  = iv;
    in_v      = v;
    in_y      = y;
    out_ready = ordy;
    @(negedge clk);
    check_all(tag);
    acc  = iv && (mq.size() < 2);
    pp   = (mq.size() > 0) && ordy;
    w.v  = v;
    w.oh = v ? (1 << y) : 0;
    @(posedge clk);
    #1;
    if (pp) begin
      last_oh = mq[0].oh;
      last_v  = mq[0].v;
      void'(mq.pop_front());
    end
    if (acc) begin
      mq.push_back(w);
      if (v) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_v = 1'b0; in_y = 2'd0; out_ready = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single word v=1,y=2
    cycle("t1_push", 1'b1, 1'b1, 2'd2, 1'b1);
    cycle("t1_out",  1'b0, 1'b0, 2'd0, 1'b1);

    // back-to-back sweep
    for (int i = 0; i < 4; i++) cycle("t2_sweep", 1'b1, 1'b1, 2'(i), 1'b1);
    cycle("t2_drain", 1'b0, 1'b0, 2'd0, 1'b1);
    cycle("t2_idle",  1'b0, 1'b0, 2'd0, 1'b1);

    // back-pressure fills both slots, then drains in order
    cycle("t3_push1", 1'b1, 1'b1, 2'd1, 1'b0);
    cycle("t3_push2", 1'b1, 1'b1, 2'd3, 1'b0);
    cycle("t3_full",  1'b1, 1'b1, 2'd0, 1'b0);
    cycle("t3_hold",  1'b0, 1'b0, 2'd0, 1'b0);
    cycle("t3_pop1",  1'b0, 1'b0, 2'd0, 1'b1);
    cycle("t3_pop2",  1'b0, 1'b0, 2'd0, 1'b1);
    cycle("t3_idle",  1'b0, 1'b0, 2'd0, 1'b1);

    // V=0 word passes through uncounted; in_y undriven must not leak
    cycle("t4_v0",   1'b1, 1'b0, 2'd3, 1'b1);
    cycle("t4_out",  1'b1, 1'b0, 2'bxx, 1'b1);
    cycle("t4_outx", 1'b0, 1'b0, 2'd0, 1'b1);
    cycle("t4_idle", 1'b0, 1'b0, 2'd0, 1'b1);

    // mid-stream reset while both slots are full
    cycle("t6_fill1", 1'b1, 1'b1, 2'd0, 1'b0);
    cycle("t6_fill2", 1'b1, 1'b1, 2'd2, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle("t6_new",  1'b1, 1'b1, 2'd1, 1'b0);
    cycle("t6_head", 1'b0, 1'b0, 2'd0, 1'b1);
    cycle("t6_idle", 1'b0, 1'b0, 2'd0, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rnd", ($urandom % 4) != 0, ($urandom % 4) != 0,
            2'($urandom_range(0, 3)), ($urandom % 3) != 0);
    end
    cycle("rnd_end", 1'b0, 1'b0, 2'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
